// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and address/burst helpers used by the burst sequencer.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_t;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3,
    SIZE_4WORD = 3'd4,
    SIZE_8WORD = 3'd5,
    SIZE_512   = 3'd6,
    SIZE_1024  = 3'd7
  } size_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } response_t;

  // Addresses are handled at 64 bits so any bus width up to 64 fits; callers truncate.
  function automatic logic [63:0] align_address(input logic [63:0] addr, input logic [2:0] size);
    return addr & ~((64'd1 << size) - 64'd1);
  endfunction

  // Address of beat idx of an incrementing burst starting at an aligned base.
  function automatic logic [63:0] new_address(input logic [63:0] base, input logic [2:0] size,
                                              input logic [8:0] idx);
    return base + ({55'd0, idx} << size);
  endfunction

  // True when the bytes of an n-beat burst from an aligned base span two 1KB pages.
  function automatic bit crosses_1kb(input logic [63:0] addr, input logic [2:0] size,
                                     input logic [8:0] n);
    logic [63:0] last_byte;
    last_byte = addr + ({55'd0, n} << size) - 64'd1;
    return addr[63:10] != last_byte[63:10];
  endfunction

  // Fixed-length INCR bursts only when the length matches and no page is crossed.
  function automatic burst_t get_burst_type(input logic [8:0] n, input bit crosses);
    burst_t burst;
    if (n == 9'd1) begin
      burst = BURST_SINGLE;
    end else if (crosses) begin
      burst = BURST_INCR;
    end else begin
      case (n)
        9'd4:    burst = BURST_INCR4;
        9'd8:    burst = BURST_INCR8;
        9'd16:   burst = BURST_INCR16;
        default: burst = BURST_INCR;
      endcase
    end
    return burst;
  endfunction

endpackage

// File: rtl/ahb_beat_addr_gen.sv
// Beat address generator: aligned base plus beat index gives the beat's HADDR
// and flags whether that address opens a new 1KB page.
module ahb_beat_addr_gen
  import ahb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] base,
  input  logic [2:0]    size,
  input  logic [8:0]    beat_idx,
  output logic [AW-1:0] beat_addr,
  output logic          kb_boundary
);

  // Beat address and page-start flag are pure functions of the burst position.
  always_comb begin
    beat_addr   = AW'(new_address(64'(base), size, beat_idx));
    kb_boundary = (beat_addr[9:0] == 10'd0);
  end

endmodule

// File: rtl/ahb_burst_sequencer.sv
// AHB-Lite master address/control sequencer: turns one burst command into
// pipelined address phases and reports data-phase completion, done and error.
module ahb_burst_sequencer
  import ahb_pkg::*;
#(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [AHB_ADDRESS_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]                   cmd_len_i,
  input  logic [2:0]                   cmd_size_i,
  input  logic                         cmd_write_i,
  input  logic                         stall_i,
  output logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
  output logic [1:0]                   HTRANS,
  output logic [2:0]                   HBURST,
  output logic [2:0]                   HSIZE,
  output logic                         HWRITE,
  input  logic                         HREADY,
  input  logic                         HRESP,
  output logic                         beat_ack_o,
  output logic                         beat_last_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int AW = AHB_ADDRESS_WIDTH;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(AHB_DATA_WIDTH / 8));

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} seq_state_t;

  seq_state_t    state;
  state_t        htrans_q;
  burst_t        hburst_q;
  size_t         hsize_q;
  logic [AW-1:0] haddr_q;
  logic          hwrite_q;
  logic [AW-1:0] base_q;
  logic [8:0]    beat_cnt;
  logic [8:0]    last_idx;
  logic          dp_active;
  logic          dp_last;

  logic [AW-1:0] cmd_base;
  logic [8:0]    cmd_beats;
  logic [8:0]    next_idx;
  logic [AW-1:0] next_addr;
  logic          next_kb;
  logic          hold_busy;
  logic          data_err;

  ahb_beat_addr_gen #(.AW(AW)) u_addr_gen (
    .base        (base_q),
    .size        (hsize_q),
    .beat_idx    (next_idx),
    .beat_addr   (next_addr),
    .kb_boundary (next_kb)
  );

  // Command decode, BUSY request and first-cycle error detection.
  always_comb begin
    cmd_base    = AW'(align_address(64'(cmd_addr_i), cmd_size_i));
    cmd_beats   = {1'b0, cmd_len_i} + 9'd1;
    next_idx    = beat_cnt + 9'd1;
    hold_busy   = stall_i && (hburst_q == BURST_INCR);
    data_err    = dp_active && !HREADY && (HRESP == RESP_ERROR);
    cmd_ready_o = (state == S_IDLE) && !dp_active;
  end

  // Data-phase reporting follows the slave response in the same cycle.
  always_comb begin
    beat_ack_o  = dp_active && HREADY && (HRESP == RESP_OKAY) && (state != S_ERR);
    beat_last_o = beat_ack_o && dp_last;
    done_o      = HREADY && (((state == S_LAST) && dp_active) || (state == S_ERR));
    err_o       = done_o && ((state == S_ERR) || (HRESP == RESP_ERROR));
  end

  // Sequencer FSM: issues address phases, tracks the outstanding data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      htrans_q  <= TRANS_IDLE;
      haddr_q   <= '0;
      hburst_q  <= BURST_SINGLE;
      hsize_q   <= SIZE_BYTE;
      hwrite_q  <= 1'b0;
      base_q    <= '0;
      beat_cnt  <= '0;
      last_idx  <= '0;
      dp_active <= 1'b0;
      dp_last   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            base_q   <= cmd_base;
            haddr_q  <= cmd_base;
            hburst_q <= get_burst_type(cmd_beats, crosses_1kb(64'(cmd_base), cmd_size_i, cmd_beats));
            hsize_q  <= size_t'(cmd_size_i);
            hwrite_q <= cmd_write_i;
            last_idx <= {1'b0, cmd_len_i};
            beat_cnt <= '0;
            htrans_q <= TRANS_NONSEQ;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (data_err) begin
            htrans_q <= TRANS_IDLE;
            state    <= S_ERR;
          end else if (HREADY) begin
            if (htrans_q == TRANS_BUSY) begin
              dp_active <= 1'b0;
              dp_last   <= 1'b0;
              if (hold_busy) begin
                htrans_q <= TRANS_BUSY;
              end else begin
                htrans_q <= (haddr_q[9:0] == 10'd0) ? TRANS_NONSEQ : TRANS_SEQ;
              end
            end else if (beat_cnt == last_idx) begin
              dp_active <= 1'b1;
              dp_last   <= 1'b1;
              htrans_q  <= TRANS_IDLE;
              state     <= S_LAST;
            end else begin
              dp_active <= 1'b1;
              dp_last   <= 1'b0;
              beat_cnt  <= next_idx;
              haddr_q   <= next_addr;
              if (hold_busy) begin
                htrans_q <= TRANS_BUSY;
              end else begin
                htrans_q <= next_kb ? TRANS_NONSEQ : TRANS_SEQ;
              end
            end
          end
        end
        S_LAST: begin
          if (data_err) begin
            state <= S_ERR;
          end else if (HREADY) begin
            dp_active <= 1'b0;
            dp_last   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_ERR: begin
          if (HREADY) begin
            dp_active <= 1'b0;
            dp_last   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Transfer sizes wider than the data bus are flagged when a command is accepted.
  always @(posedge clk) begin
    if (!rst && cmd_valid_i && cmd_ready_o) begin
      assert (cmd_size_i <= MAX_SIZE);
    end
  end

  assign HTRANS = htrans_q;
  assign HADDR  = haddr_q;
  assign HBURST = hburst_q;
  assign HSIZE  = hsize_q;
  assign HWRITE = hwrite_q;

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Self-checking bench for ahb_burst_sequencer: directed bursts with a scoreboard
// of expected address phases, beat acks and completions.
module tb_ahb_burst_sequencer;

  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdAddr;
  logic [7:0]  cmdLen;
  logic [2:0]  cmdSize;
  logic        cmdWrite;
  logic        stall;
  logic [31:0] hAddr;
  logic [1:0]  hTrans;
  logic [2:0]  hBurst;
  logic [2:0]  hSize;
  logic        hWrite;
  logic        hReady;
  logic        hResp;
  logic        beatAck;
  logic        beatLast;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [1:0]  expTrans[$];
  logic [31:0] expAddr[$];
  logic        expLast[$];
  logic        expErr[$];
  logic [2:0]  expBurst;
  logic [2:0]  expSize;
  logic        expWrite;

  logic [1:0]  monTrans;
  logic [31:0] monAddr;
  logic        monFlag;
  int          cyc;

  ahb_burst_sequencer #(.AHB_DATA_WIDTH(64), .AHB_ADDRESS_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReady),
    .cmd_addr_i  (cmdAddr),
    .cmd_len_i   (cmdLen),
    .cmd_size_i  (cmdSize),
    .cmd_write_i (cmdWrite),
    .stall_i     (stall),
    .HADDR       (hAddr),
    .HTRANS      (hTrans),
    .HBURST      (hBurst),
    .HSIZE       (hSize),
    .HWRITE      (hWrite),
    .HREADY      (hReady),
    .HRESP       (hResp),
    .beat_ack_o  (beatAck),
    .beat_last_o (beatLast),
    .done_o      (done),
    .err_o       (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference burst-type rule, written from the address arithmetic directly.
  function automatic logic [2:0] modelBurst(input logic [63:0] base, input int n, input logic [2:0] size);
    logic [63:0] lastByte;
    lastByte = base + (64'(n) << size) - 64'd1;
    if (n == 1) return 3'd0;
    if ((base >> 10) != (lastByte >> 10)) return 3'd1;
    case (n)
      4:       return 3'd3;
      8:       return 3'd5;
      16:      return 3'd7;
      default: return 3'd1;
    endcase
  endfunction

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pushes the expected transfers/acks/completion, then hands the command over.
  // Returns 1 time unit after the accepting edge (first address-phase cycle).
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic wr, input int busyAfter, input int busyN, input int errBeat);
    logic [63:0] base;
    logic [63:0] beatAddr;
    int n;
    int lastAddrBeat;
    int waitCnt;
    n = int'(len) + 1;
    base = {32'd0, addr} & ~((64'd1 << size) - 64'd1);
    expBurst = modelBurst(base, n, size);
    expSize  = size;
    expWrite = wr;
    lastAddrBeat = (errBeat >= 0) ? errBeat : n - 1;
    for (int k = 0; k <= lastAddrBeat; k++) begin
      beatAddr = base + (64'(k) << size);
      expTrans.push_back((k == 0 || beatAddr[9:0] == 10'd0) ? 2'd2 : 2'd3);
      expAddr.push_back(beatAddr[31:0]);
      if (k == busyAfter && expBurst == 3'd1) begin
        for (int b = 0; b < busyN; b++) begin
          expTrans.push_back(2'd1);
          expAddr.push_back(beatAddr[31:0] + (32'd1 << size));
        end
      end
    end
    if (errBeat >= 0) begin
      for (int k = 0; k < errBeat; k++) expLast.push_back(1'b0);
      expErr.push_back(1'b1);
    end else begin
      for (int k = 0; k < n; k++) expLast.push_back(k == n - 1);
      expErr.push_back(1'b0);
    end
    cmdAddr  = addr;
    cmdLen   = len;
    cmdSize  = size;
    cmdWrite = wr;
    cmdValid = 1'b1;
    waitCnt  = 0;
    @(negedge clk);
    while (!cmdReady && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmdReady) checkOutput("cmd_ready_timeout", {31'd0, cmdReady}, 32'd1);
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  // Counts cycles (this one included) until done_o, bounded.
  task automatic waitDone(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 200);
    if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: compares each completed address phase, beat ack and completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (hReady && hTrans != 2'd0) begin
        if (expTrans.size() == 0) begin
          checkOutput("unexpected_transfer", {30'd0, hTrans}, 32'd0);
        end else begin
          monTrans = expTrans.pop_front();
          monAddr  = expAddr.pop_front();
          checkOutput("htrans", {30'd0, hTrans}, {30'd0, monTrans});
          checkOutput("haddr", hAddr, monAddr);
          checkOutput("hburst", {29'd0, hBurst}, {29'd0, expBurst});
          checkOutput("hsize", {29'd0, hSize}, {29'd0, expSize});
          checkOutput("hwrite", {31'd0, hWrite}, {31'd0, expWrite});
        end
      end
      if (beatAck) begin
        if (expLast.size() == 0) begin
          checkOutput("unexpected_ack", 32'd1, 32'd0);
        end else begin
          monFlag = expLast.pop_front();
          checkOutput("beat_last", {31'd0, beatLast}, {31'd0, monFlag});
        end
      end
      if (done) begin
        if (expErr.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          monFlag = expErr.pop_front();
          checkOutput("done_err", {31'd0, err}, {31'd0, monFlag});
        end
      end
    end
  end

  // Directed sequence of bursts.
  initial begin
    rst = 1'b1;
    cmdValid = 1'b0;
    cmdAddr = '0;
    cmdLen = '0;
    cmdSize = '0;
    cmdWrite = 1'b0;
    stall = 1'b0;
    hReady = 1'b1;
    hResp = 1'b0;
    expBurst = '0;
    expSize = '0;
    expWrite = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_htrans", {30'd0, hTrans}, 32'd0);
    checkOutput("reset_haddr", hAddr, 32'd0);
    checkOutput("reset_hburst", {29'd0, hBurst}, 32'd0);
    checkOutput("reset_hsize", {29'd0, hSize}, 32'd0);
    checkOutput("reset_hwrite", {31'd0, hWrite}, 32'd0);
    checkOutput("reset_cmd_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("reset_beat_ack", {31'd0, beatAck}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    stepCycles(1);

    $display("[TB] burst 1: INCR4 write at 0x100");
    applyStimulus(32'h100, 8'd3, 3'd3, 1'b1, -1, 0, -1);
    waitDone(cyc);
    checkOutput("t1_done_latency", cyc, 32'd5);
    stepCycles(1);

    $display("[TB] burst 2: 1KB crossing at 0x3F8");
    applyStimulus(32'h3F8, 8'd3, 3'd3, 1'b0, -1, 0, -1);
    waitDone(cyc);
    checkOutput("t2_done_latency", cyc, 32'd5);
    stepCycles(1);

    $display("[TB] burst 3: single unaligned read");
    applyStimulus(32'h13, 8'd0, 3'd2, 1'b0, -1, 0, -1);
    waitDone(cyc);
    checkOutput("t3_done_latency", cyc, 32'd2);
    stepCycles(1);

    $display("[TB] burst 4: INCR with two BUSY cycles");
    applyStimulus(32'h200, 8'd5, 3'd3, 1'b1, 1, 2, -1);
    stepCycles(1);
    stall = 1'b1;
    stepCycles(2);
    stall = 1'b0;
    waitDone(cyc);
    checkOutput("t4_done_latency", cyc, 32'd6);
    stepCycles(1);

    $display("[TB] burst 5: INCR8 with wait states on beat 2");
    applyStimulus(32'h40, 8'd7, 3'd2, 1'b0, -1, 0, -1);
    stepCycles(2);
    hReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t5_wait_htrans", {30'd0, hTrans}, 32'd3);
      checkOutput("t5_wait_haddr", hAddr, 32'h48);
      checkOutput("t5_wait_ack", {31'd0, beatAck}, 32'd0);
      @(posedge clk);
      #1;
    end
    hReady = 1'b1;
    waitDone(cyc);
    checkOutput("t5_done_latency", cyc, 32'd7);
    stepCycles(1);

    $display("[TB] burst 6: ERROR response on beat 1");
    applyStimulus(32'h500, 8'd3, 3'd3, 1'b1, -1, 0, 1);
    stepCycles(2);
    hReady = 1'b0;
    hResp = 1'b1;
    stepCycles(1);
    hReady = 1'b1;
    @(negedge clk);
    checkOutput("t6_htrans_idle", {30'd0, hTrans}, 32'd0);
    checkOutput("t6_done", {31'd0, done}, 32'd1);
    checkOutput("t6_err", {31'd0, err}, 32'd1);
    checkOutput("t6_no_ack", {31'd0, beatAck}, 32'd0);
    @(posedge clk);
    #1 hResp = 1'b0;
    @(negedge clk);
    checkOutput("t6_ready_after", {31'd0, cmdReady}, 32'd1);
    checkOutput("t6_trans_left", expTrans.size(), 32'd0);
    checkOutput("t6_acks_left", expLast.size(), 32'd0);
    checkOutput("t6_done_left", expErr.size(), 32'd0);
    stepCycles(1);

    $display("[TB] burst 7: reset in the middle of an INCR16");
    applyStimulus(32'h0, 8'd15, 3'd0, 1'b1, -1, 0, -1);
    stepCycles(3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t7_reset_htrans", {30'd0, hTrans}, 32'd0);
    checkOutput("t7_reset_haddr", hAddr, 32'd0);
    checkOutput("t7_reset_hburst", {29'd0, hBurst}, 32'd0);
    checkOutput("t7_reset_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("t7_reset_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    expTrans.delete();
    expAddr.delete();
    expLast.delete();
    expErr.delete();
    stepCycles(4);
    applyStimulus(32'h13, 8'd0, 3'd2, 1'b0, -1, 0, -1);
    waitDone(cyc);
    checkOutput("t7_recover_latency", cyc, 32'd2);
    stepCycles(2);
    checkOutput("final_trans_left", expTrans.size(), 32'd0);
    checkOutput("final_acks_left", expLast.size(), 32'd0);
    checkOutput("final_done_left", expErr.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
